// File: rtl/ftof_arbiter_if.sv
// Bundle of request, datapath and response signals shared between the
// float-to-float conversion arbiter and its surroundings.
interface ftof_arbiter_if #(
    parameter int FLEN = 64
);
    logic            req0_valid;
    logic            req0_ready;
    logic [FLEN-1:0] req0_a;
    logic [2:0]      req0_rm;
    logic            req0_ctrl;

    logic            req1_valid;
    logic            req1_ready;
    logic [FLEN-1:0] req1_a;
    logic [2:0]      req1_rm;
    logic            req1_ctrl;

    logic            dp_valid;
    logic [FLEN-1:0] dp_a;
    logic [2:0]      dp_rm;
    logic            dp_ctrl;
    logic [FLEN-1:0] dp_out;
    logic [4:0]      dp_flags;

    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [FLEN-1:0] rsp0_out;
    logic [4:0]      rsp0_flags;

    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [FLEN-1:0] rsp1_out;
    logic [4:0]      rsp1_flags;

    // Arbiter side of the bundle
    modport slave (
        input  req0_valid, req0_a, req0_rm, req0_ctrl,
        input  req1_valid, req1_a, req1_rm, req1_ctrl,
        input  dp_out, dp_flags,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output dp_valid, dp_a, dp_rm, dp_ctrl,
        output rsp0_valid, rsp0_out, rsp0_flags,
        output rsp1_valid, rsp1_out, rsp1_flags
    );

    // Requesters, datapath and response consumers
    modport master (
        output req0_valid, req0_a, req0_rm, req0_ctrl,
        output req1_valid, req1_a, req1_rm, req1_ctrl,
        output dp_out, dp_flags,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  dp_valid, dp_a, dp_rm, dp_ctrl,
        input  rsp0_valid, rsp0_out, rsp0_flags,
        input  rsp1_valid, rsp1_out, rsp1_flags
    );
endinterface

// File: rtl/ftof_arbiter.sv
// Two-port round-robin front end for a shared fixed-latency float-to-float
// conversion datapath. Each requester owns a small response FIFO, and a
// credit count (ops in flight plus ops buffered) guarantees that every
// result leaving the datapath has a slot waiting for it.
module ftof_arbiter #(
    parameter int FLEN       = 64,
    parameter int LAT        = 1,
    parameter int RESP_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    ftof_arbiter_if.slave bus
);
    localparam int PW = (RESP_DEPTH > 2) ? 2 : 1;
    localparam int EW = FLEN + 5;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rrState_t;

    rrState_t       rrPtr;
    logic [LAT-1:0] trkValid;
    logic [LAT-1:0] trkId;
    logic [EW-1:0]  fifoMem   [2][RESP_DEPTH];
    logic [PW-1:0]  rdPtr     [2];
    logic [PW-1:0]  wrPtr     [2];
    logic [3:0]     fifoCount [2];
    logic [3:0]     inflight  [2];
    logic [3:0]     avail     [2];
    logic [1:0]     push;
    logic [1:0]     pop;
    logic           elig0;
    logic           elig1;
    logic           grant0;
    logic           grant1;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Count how many ops of each requester are still travelling through the datapath
    always_comb begin
        inflight[0] = 4'd0;
        inflight[1] = 4'd0;
        for (int k = 0; k < LAT; k++) begin
            if (trkValid[k]) begin
                if (trkId[k]) inflight[1] = inflight[1] + 4'd1;
                else          inflight[0] = inflight[0] + 4'd1;
            end
        end
    end

    // Credits, eligibility and the round-robin grant; nothing is issued while reset is held
    always_comb begin
        avail[0] = 4'(RESP_DEPTH) - inflight[0] - fifoCount[0];
        avail[1] = 4'(RESP_DEPTH) - inflight[1] - fifoCount[1];
        elig0    = bus.req0_valid && (avail[0] != 4'd0);
        elig1    = bus.req1_valid && (avail[1] != 4'd0);
        grant0   = !rst && elig0 && (!elig1 || (rrPtr == PRIO_REQ0));
        grant1   = !rst && elig1 && (!elig0 || (rrPtr == PRIO_REQ1));
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Steer the granted request onto the datapath, zeroing the bus when idle
    always_comb begin
        bus.dp_valid = grant0 || grant1;
        bus.dp_a     = '0;
        bus.dp_rm    = 3'd0;
        bus.dp_ctrl  = 1'b0;
        if (grant0) begin
            bus.dp_a    = bus.req0_a;
            bus.dp_rm   = bus.req0_rm;
            bus.dp_ctrl = bus.req0_ctrl;
        end else if (grant1) begin
            bus.dp_a    = bus.req1_a;
            bus.dp_rm   = bus.req1_rm;
            bus.dp_ctrl = bus.req1_ctrl;
        end
    end

    // Round-robin pointer: after a grant the other requester gets priority
    always_ff @(posedge clk) begin
        if (rst)         rrPtr <= PRIO_REQ0;
        else if (grant0) rrPtr <= PRIO_REQ1;
        else if (grant1) rrPtr <= PRIO_REQ0;
    end

    // Shadow the datapath pipeline with {valid, requester id} so results can be routed
    always_ff @(posedge clk) begin
        if (rst) begin
            trkValid <= '0;
            trkId    <= '0;
        end else begin
            trkValid[0] <= bus.dp_valid;
            trkId[0]    <= grant1;
            for (int k = 1; k < LAT; k++) begin
                trkValid[k] <= trkValid[k-1];
                trkId[k]    <= trkId[k-1];
            end
        end
    end

    // A result leaving the last stage goes to its requester's FIFO; heads pop on valid&ready
    always_comb begin
        push[0] = trkValid[LAT-1] && !trkId[LAT-1];
        push[1] = trkValid[LAT-1] &&  trkId[LAT-1];
        pop[0]  = bus.rsp0_ready && (fifoCount[0] != 4'd0);
        pop[1]  = bus.rsp1_ready && (fifoCount[1] != 4'd0);
    end

    // FIFO storage; a full FIFO may be written in the same cycle its head is popped
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i] && !rst) fifoMem[i][wrPtr[i]] <= {bus.dp_flags, bus.dp_out};
        end
    end

    // FIFO pointers and occupancy; overflow would mean the credit scheme is broken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rdPtr[i]     <= '0;
                wrPtr[i]     <= '0;
                fifoCount[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                assert (!(push[i] && !pop[i] && (fifoCount[i] >= 4'(RESP_DEPTH))));
                if (push[i]) wrPtr[i] <= nextPtr(wrPtr[i]);
                if (pop[i])  rdPtr[i] <= nextPtr(rdPtr[i]);
                case ({push[i], pop[i]})
                    2'b10:   fifoCount[i] <= fifoCount[i] + 4'd1;
                    2'b01:   fifoCount[i] <= fifoCount[i] - 4'd1;
                    default: fifoCount[i] <= fifoCount[i];
                endcase
            end
        end
    end

    assign bus.rsp0_valid = (fifoCount[0] != 4'd0);
    assign bus.rsp1_valid = (fifoCount[1] != 4'd0);
    assign {bus.rsp0_flags, bus.rsp0_out} = fifoMem[0][rdPtr[0]];
    assign {bus.rsp1_flags, bus.rsp1_out} = fifoMem[1][rdPtr[1]];
endmodule

// File: tb/tb_ftof_arbiter.sv
// Bench for ftof_arbiter: the same stimulus drives a LAT=1 and a LAT=3 instance,
// each paired with a fake conversion datapath and an outstanding-op queue model.
module tb_ftof_arbiter;
    localparam int FLEN  = 64;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] out;
        logic [4:0]  flags;
        logic [31:0] due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rr0, rr1, c0, c1;
    logic [63:0] a0, a1;
    logic [2:0]  rm0, rm1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          count1;

    always #5 clk = ~clk;

    // Cycle index used to time when a result becomes visible
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] dpOut(input logic [63:0] a, input logic [2:0] rm, input logic c);
        return {a[31:0], a[63:32]} ^ {61'd0, rm} ^ (c ? 64'hFFFF_0000_FFFF_0000 : 64'd0);
    endfunction

    function automatic logic [4:0] dpFlags(input logic [63:0] a, input logic [2:0] rm, input logic c);
        return a[4:0] ^ {rm, c, 1'b1};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic val0, input logic val1,
                                 input logic ready0, input logic ready1);
        @(posedge clk);
        #1;
        rst = r;
        v0  = val0;
        v1  = val1;
        rr0 = ready0;
        rr1 = ready1;
        a0  = {$urandom, $urandom};
        a1  = {$urandom, $urandom};
        rm0 = 3'($urandom_range(0, 7));
        rm1 = 3'($urandom_range(0, 7));
        c0  = 1'($urandom_range(0, 1));
        c1  = 1'($urandom_range(0, 1));
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;

        ftof_arbiter_if #(.FLEN(FLEN)) bus ();

        assign bus.req0_valid = v0;
        assign bus.req0_a     = a0;
        assign bus.req0_rm    = rm0;
        assign bus.req0_ctrl  = c0;
        assign bus.req1_valid = v1;
        assign bus.req1_a     = a1;
        assign bus.req1_rm    = rm1;
        assign bus.req1_ctrl  = c1;
        assign bus.rsp0_ready = rr0;
        assign bus.rsp1_ready = rr1;

        ftof_arbiter #(.FLEN(FLEN), .LAT(L), .RESP_DEPTH(DEPTH)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        logic        pv  [L];
        logic [63:0] pa  [L];
        logic [2:0]  prm [L];
        logic        pc  [L];

        // Fake datapath: a fixed L-cycle pipeline with no reset of its own
        always @(posedge clk) begin
            pv[0]  <= bus.dp_valid;
            pa[0]  <= bus.dp_a;
            prm[0] <= bus.dp_rm;
            pc[0]  <= bus.dp_ctrl;
            for (int k = 1; k < L; k++) begin
                pv[k]  <= pv[k-1];
                pa[k]  <= pa[k-1];
                prm[k] <= prm[k-1];
                pc[k]  <= pc[k-1];
            end
        end

        assign bus.dp_out   = pv[L-1] ? dpOut(pa[L-1], prm[L-1], pc[L-1]) : 64'hDEAD_BEEF_DEAD_BEEF;
        assign bus.dp_flags = pv[L-1] ? dpFlags(pa[L-1], prm[L-1], pc[L-1]) : 5'h1F;

        rsp_t q0[$];
        rsp_t q1[$];
        rsp_t item;
        bit   favour;
        bit   e0, e1, g0, g1, ev0, ev1;

        // Model: each queue holds every accepted-but-unconsumed op, so its size is the credit use
        always @(negedge clk) begin
            if (rst) begin
                q0.delete();
                q1.delete();
                favour = 1'b0;
            end else begin
                e0  = v0 && (q0.size() < DEPTH);
                e1  = v1 && (q1.size() < DEPTH);
                g0  = e0 && (!e1 || !favour);
                g1  = e1 && (!e0 || favour);
                ev0 = (q0.size() > 0) && (int'(q0[0].due) <= cyc);
                ev1 = (q1.size() > 0) && (int'(q1[0].due) <= cyc);
                checkOutput($sformatf("L%0d req0_ready", L), bus.req0_ready, g0);
                checkOutput($sformatf("L%0d req1_ready", L), bus.req1_ready, g1);
                checkOutput($sformatf("L%0d dp_valid", L), bus.dp_valid, g0 | g1);
                checkOutput($sformatf("L%0d dp_a", L), bus.dp_a, g0 ? a0 : (g1 ? a1 : 64'd0));
                checkOutput($sformatf("L%0d dp_rm", L), bus.dp_rm, g0 ? rm0 : (g1 ? rm1 : 3'd0));
                checkOutput($sformatf("L%0d dp_ctrl", L), bus.dp_ctrl, g0 ? c0 : (g1 ? c1 : 1'b0));
                checkOutput($sformatf("L%0d rsp0_valid", L), bus.rsp0_valid, ev0);
                checkOutput($sformatf("L%0d rsp1_valid", L), bus.rsp1_valid, ev1);
                if (ev0) begin
                    checkOutput($sformatf("L%0d rsp0_out", L), bus.rsp0_out, q0[0].out);
                    checkOutput($sformatf("L%0d rsp0_flags", L), bus.rsp0_flags, q0[0].flags);
                    if (rr0) void'(q0.pop_front());
                end
                if (ev1) begin
                    checkOutput($sformatf("L%0d rsp1_out", L), bus.rsp1_out, q1[0].out);
                    checkOutput($sformatf("L%0d rsp1_flags", L), bus.rsp1_flags, q1[0].flags);
                    if (rr1) void'(q1.pop_front());
                end
                if (g0) begin
                    item.out   = dpOut(a0, rm0, c0);
                    item.flags = dpFlags(a0, rm0, c0);
                    item.due   = 32'(cyc + L + 1);
                    q0.push_back(item);
                    favour = 1'b1;
                end else if (g1) begin
                    item.out   = dpOut(a1, rm1, c1);
                    item.flags = dpFlags(a1, rm1, c1);
                    item.due   = 32'(cyc + L + 1);
                    q1.push_back(item);
                    favour = 1'b0;
                end
            end
        end
    end

    // Directed scenarios followed by a randomized soak
    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        a0 = '0; a1 = '0; rm0 = '0; rm1 = '0; c0 = 1'b0; c1 = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("reset rsp0_valid", inst[0].bus.rsp0_valid, 1'b0);
        checkOutput("reset rsp1_valid", inst[0].bus.rsp1_valid, 1'b0);
        checkOutput("reset dp_valid", inst[0].bus.dp_valid, 1'b0);
        checkOutput("reset L3 rsp0_valid", inst[1].bus.rsp0_valid, 1'b0);

        // Single op: accepted at once, response two cycles later for LAT=1
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        a0 = 64'h3FF0_0000_0000_0000; rm0 = 3'd0; c0 = 1'b0;
        @(negedge clk);
        checkOutput("first req0_ready", inst[0].bus.req0_ready, 1'b1);
        checkOutput("first dp_valid", inst[0].bus.dp_valid, 1'b1);
        checkOutput("first dp_a", inst[0].bus.dp_a, 64'h3FF0_0000_0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("first rsp0 too early", inst[0].bus.rsp0_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("first rsp0_valid", inst[0].bus.rsp0_valid, 1'b1);
        checkOutput("first rsp0_out", inst[0].bus.rsp0_out, 64'h0000_0000_3FF0_0000);
        checkOutput("first rsp0_flags", inst[0].bus.rsp0_flags, 5'h01);

        // Both requesting: pointer favours 1 after the last grant to 0, then alternates
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("alternate req1_ready %0d", k), inst[0].bus.req1_ready, (k % 2) == 0);
        end
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stalled consumer 1: only two credits, then one pop frees exactly one more
        count1 = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (inst[0].bus.req1_ready) count1++;
        end
        checkOutput("stall req1 accepts", 64'(count1), 64'd2);
        checkOutput("stall rsp1_valid", inst[0].bus.rsp1_valid, 1'b1);
        count1 = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        if (inst[0].bus.req1_ready) count1++;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (inst[0].bus.req1_ready) count1++;
        end
        checkOutput("stall one more req1", 64'(count1), 64'd1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Fill FIFO0, then stream with simultaneous push and pop
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("full req0_ready", inst[0].bus.req0_ready, 1'b0);
        checkOutput("full rsp0_valid", inst[0].bus.rsp0_valid, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // LAT=3: reset lands in the cycle the first result leaves the datapath
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("midreset L3 req0_ready", inst[1].bus.req0_ready, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("midreset L3 rsp0_valid %0d", k), inst[1].bus.rsp0_valid, 1'b0);
            checkOutput($sformatf("midreset L3 rsp1_valid %0d", k), inst[1].bus.rsp1_valid, 1'b0);
        end

        // A lone requester is granted whichever way the pointer points
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("lone req0 against pointer", inst[0].bus.req0_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("lone req1 with pointer", inst[0].bus.req1_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("lone req1 against pointer", inst[0].bus.req1_ready, 1'b1);

        // Random traffic, random backpressure, occasional reset
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
